// File: rtl/vga_vtiming_if.sv
// Signal bundle between the horizontal timing stage and the vertical timing
// generator: hsync in, vertical timing and sync-health status out.
interface vga_vtiming_if;
   logic        hsync;        // active-high horizontal sync, synchronous to clk
   logic        vsync;        // active-high vertical sync
   logic [15:0] vcount;       // current line number
   logic        v_visible;    // current line is in the visible region
   logic        frame_start;  // one-clk pulse when a new frame begins
   logic        sync_lost;    // no valid hsync cadence present

   // Horizontal stage side: drives hsync, observes vertical timing
   modport master (
      output hsync,
      input  vsync,
      input  vcount,
      input  v_visible,
      input  frame_start,
      input  sync_lost
   );

   // Vertical timing generator side
   modport slave (
      input  hsync,
      output vsync,
      output vcount,
      output v_visible,
      output frame_start,
      output sync_lost
   );
endinterface

// File: rtl/vga_vtiming.sv
// Vertical timing generator: counts lines from hsync rising edges, decodes
// vsync / visible region, flags frame starts and detects loss of hsync cadence.
module vga_vtiming #(
   parameter logic [15:0] V_VISIBLE_END     = 16'd599,
   parameter logic [15:0] V_FRONT_PORCH_END = 16'd600,
   parameter logic [15:0] V_SYNC_PULSE_END  = 16'd604,
   parameter logic [15:0] V_BACK_PORCH_END  = 16'd627,
   parameter logic [15:0] LINE_TIMEOUT      = 16'd8191
) (
   input  logic         clk,
   input  logic         rst,
   vga_vtiming_if.slave tmg
);

   localparam int unsigned CW = 16;

   logic          hsync_q;
   logic          line_edge_c;

   logic [CW-1:0] tmo_q,       tmo_d;
   logic [CW-1:0] vcount_q,    vcount_d;
   logic          vsync_q,     vsync_d;
   logic          v_visible_q, v_visible_d;
   logic          frame_start_q, frame_start_d;
   logic          sync_lost_q, sync_lost_d;

   logic [CW-1:0] tmo_inc_c;
   logic [CW-1:0] vcount_inc_c;
   logic          wrap_c;

   // Line edge: hsync newly high this clk; hsync_q resets high so a level
   // already present at reset release is not mistaken for an edge
   assign line_edge_c = tmg.hsync & ~hsync_q;

   // Saturating timeout increment and wrapping line increment
   always_comb begin
      tmo_inc_c    = (tmo_q >= LINE_TIMEOUT) ? LINE_TIMEOUT : CW'(tmo_q + CW'(1));
      wrap_c       = (vcount_q >= V_BACK_PORCH_END);
      vcount_inc_c = wrap_c ? '0 : CW'(vcount_q + CW'(1));
   end

   // Next-state: a line edge advances or resynchronises, otherwise the
   // timeout runs and forces the lost-sync state when it expires
   always_comb begin
      tmo_d         = tmo_q;
      vcount_d      = vcount_q;
      vsync_d       = vsync_q;
      v_visible_d   = v_visible_q;
      frame_start_d = 1'b0;
      sync_lost_d   = sync_lost_q;

      if (line_edge_c) begin
         tmo_d = '0;
         if (sync_lost_q) begin
            // First edge after loss restarts the frame without a frame pulse
            vcount_d    = '0;
            sync_lost_d = 1'b0;
         end else begin
            vcount_d      = vcount_inc_c;
            frame_start_d = wrap_c;
         end
         vsync_d     = (vcount_d > V_FRONT_PORCH_END) && (vcount_d <= V_SYNC_PULSE_END);
         v_visible_d = (vcount_d <= V_VISIBLE_END);
      end else begin
         tmo_d = tmo_inc_c;
         if (tmo_inc_c == LINE_TIMEOUT) begin
            // Re-applied every clk while saturated, which keeps outputs parked
            sync_lost_d = 1'b1;
            vcount_d    = '0;
            vsync_d     = 1'b0;
            v_visible_d = 1'b0;
         end
      end
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_q       <= 1'b1;
         tmo_q         <= '0;
         vcount_q      <= '0;
         vsync_q       <= 1'b0;
         v_visible_q   <= 1'b0;
         frame_start_q <= 1'b0;
         sync_lost_q   <= 1'b1;
      end else begin
         hsync_q       <= tmg.hsync;
         tmo_q         <= tmo_d;
         vcount_q      <= vcount_d;
         vsync_q       <= vsync_d;
         v_visible_q   <= v_visible_d;
         frame_start_q <= frame_start_d;
         sync_lost_q   <= sync_lost_d;
      end
   end

   assign tmg.vcount      = vcount_q;
   assign tmg.vsync       = vsync_q;
   assign tmg.v_visible   = v_visible_q;
   assign tmg.frame_start = frame_start_q;
   assign tmg.sync_lost   = sync_lost_q;

endmodule
